// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the MIPS instruction-fetch slice.
//   WORD          : datapath / address width
//   NOP           : encoding loaded into IF/ID when no instruction is present
//   fetch_state_e : state encoding of the instruction-fetch FSM
package mips_pkg;

  localparam int WORD = 32;
  localparam logic [WORD-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no request outstanding; next cycle issues a fetch
    ST_REQ  = 2'd1,  // request outstanding, result wanted
    ST_HOLD = 2'd2,  // result fetched but IF/ID stalled; data in hold buffer
    ST_DROP = 2'd3   // request outstanding, result no longer wanted
  } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg -- IF/ID pipeline register.
//   clk, reset     : clock, synchronous active-high reset
//   flush_i        : clear to NOP with pc4 = 0 (highest priority)
//   stall_i        : hold current contents
//   load_i         : load instr_i / pc4_i as a valid instruction
//   instr_i, pc4_i : instruction and fetch address + 4 to load
//   valid_o, instr_o, pc4_o : register contents
// With no flush, stall or load, a bubble (valid = 0, instr = NOP) is
// inserted; pc4 keeps its previous value since it is meaningless then.
module ifid_reg
  import mips_pkg::*;
#(
  parameter int word = WORD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            load_i,
  input  logic [word-1:0] instr_i,
  input  logic [word-1:0] pc4_i,
  output logic            valid_o,
  output logic [word-1:0] instr_o,
  output logic [word-1:0] pc4_o
);

  logic            valid_q, valid_d;
  logic [word-1:0] instr_q, instr_d;
  logic [word-1:0] pc4_q,   pc4_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = word'(NOP);
      pc4_d   = '0;
    end else if (stall_i) begin
      valid_d = valid_q;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc4_d   = pc4_i;
    end else begin
      valid_d = 1'b0;
      instr_d = word'(NOP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl -- instruction-fetch controller with IF/ID register.
//   clk, reset   : clock, synchronous active-high reset
//   pc_curr      : current PC value
//   pc_write     : PC register write enable (combinational)
//   imem_req     : instruction-memory request, held until imem_ack
//   imem_addr    : word-aligned request address
//   imem_ack     : one-cycle read completion, imem_rdata valid with it
//   imem_rdata   : fetched instruction
//   stall        : hazard-unit hold of IF/ID
//   flush        : branch/jump redirect
//   ifid_valid, ifid_instr, ifid_pc4 : IF/ID register contents
// A fetch takes an IDLE cycle (address latch) plus one or more REQ cycles.
// A result arriving under stall is parked in a hold buffer until release;
// a request overtaken by a flush is completed on the bus and discarded.
module if_fetch_ctrl
  import mips_pkg::*;
#(
  parameter int word = WORD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [word-1:0] pc_curr,
  output logic            pc_write,
  output logic            imem_req,
  output logic [word-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [word-1:0] imem_rdata,
  input  logic            stall,
  input  logic            flush,
  output logic            ifid_valid,
  output logic [word-1:0] ifid_instr,
  output logic [word-1:0] ifid_pc4
);

  fetch_state_e    state_q, state_d;
  logic [word-1:0] addr_q, addr_d;
  logic [word-1:0] hold_instr_q, hold_instr_d;
  logic [word-1:0] hold_pc4_q, hold_pc4_d;

  logic            deliver;     // IF/ID receives a new instruction this cycle
  logic            from_hold;   // ... and it comes from the hold buffer
  logic [word-1:0] fetch_pc4;
  logic [word-1:0] load_instr;
  logic [word-1:0] load_pc4;

  assign fetch_pc4 = addr_q + word'(4);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    deliver      = 1'b0;
    from_hold    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A redirect is writing the PC this cycle; fetch from the new PC next.
        if (!flush) begin
          addr_d  = pc_curr & ~word'(3);
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (imem_ack) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else if (stall) begin
            hold_instr_d = imem_rdata;
            hold_pc4_d   = fetch_pc4;
            state_d      = ST_HOLD;
          end else begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (flush) begin
          // Memory cannot cancel a request; let it finish and drop the data.
          state_d = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (!stall) begin
          deliver   = 1'b1;
          from_hold = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (imem_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      hold_instr_q <= '0;
      hold_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

  assign imem_req   = (state_q == ST_REQ) || (state_q == ST_DROP);
  assign imem_addr  = addr_q;
  // The PC advances exactly when an instruction enters IF/ID.
  assign pc_write   = deliver && !reset;
  assign load_instr = from_hold ? hold_instr_q : imem_rdata;
  assign load_pc4   = from_hold ? hold_pc4_q : fetch_pc4;

  ifid_reg #(
    .word(word)
  ) u_ifid_reg (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .stall_i (stall),
    .load_i  (deliver),
    .instr_i (load_instr),
    .pc4_i   (load_pc4),
    .valid_o (ifid_valid),
    .instr_o (ifid_instr),
    .pc4_o   (ifid_pc4)
  );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_curr;
  logic        pc_write;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  if_fetch_ctrl #(.word(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_curr    (pc_curr),
    .pc_write   (pc_write),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .flush      (flush),
    .ifid_valid (ifid_valid),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Compare IF/ID against the oldest expected delivery, if any.
  task automatic drain();
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("ifid_valid", {31'b0, ifid_valid}, 32'd1);
      check_val("ifid_instr", ifid_instr, e.instr);
      check_val("ifid_pc4", ifid_pc4, e.pc4);
      $display("txn: instr=%h pc4=%h (exp %h %h)", ifid_instr, ifid_pc4, e.instr, e.pc4);
    end
  endtask

  // One fetch: IDLE cycle, dly REQ cycles without ack, ack cycle.
  // stall_hold < 0: no stall; otherwise stall at ack plus stall_hold cycles.
  task automatic fetch(input logic [31:0] pc, input int dly, input int stall_hold);
    logic [31:0] ea;
    logic [31:0] rd;
    ea = pc & 32'hFFFF_FFFC;
    rd = $urandom;
    pc_curr = pc; imem_ack = 1'b0; flush = 1'b0; stall = 1'b0;
    #1;
    drain();
    check_val("idle_req", {31'b0, imem_req}, 32'd0);
    check_val("idle_pcw", {31'b0, pc_write}, 32'd0);
    cyc();
    for (int i = 0; i < dly; i++) begin
      check_val("wait_req", {31'b0, imem_req}, 32'd1);
      check_val("wait_addr", imem_addr, ea);
      check_val("wait_pcw", {31'b0, pc_write}, 32'd0);
      check_val("wait_bubble", {31'b0, ifid_valid}, 32'd0);
      cyc();
    end
    imem_ack = 1'b1; imem_rdata = rd; stall = (stall_hold >= 0);
    #1;
    check_val("ack_req", {31'b0, imem_req}, 32'd1);
    check_val("ack_addr", imem_addr, ea);
    check_val("ack_pcw", {31'b0, pc_write}, (stall_hold >= 0) ? 32'd0 : 32'd1);
    sb_q.push_back('{instr: rd, pc4: ea + 32'd4});
    cyc();
    imem_ack = 1'b0; imem_rdata = $urandom;
    if (stall_hold >= 0) begin
      for (int i = 0; i < stall_hold; i++) begin
        #1;
        check_val("stall_pcw", {31'b0, pc_write}, 32'd0);
        check_val("stall_valid", {31'b0, ifid_valid}, 32'd0);
        check_val("stall_instr", ifid_instr, 32'd0);
        check_val("stall_req", {31'b0, imem_req}, 32'd0);
        cyc();
      end
      stall = 1'b0;
      #1;
      check_val("release_pcw", {31'b0, pc_write}, 32'd1);
      check_val("release_valid", {31'b0, ifid_valid}, 32'd0);
      cyc();
    end
  endtask

  // Flush one cycle after the request, ack arrives drop_wait+1 cycles later.
  task automatic flush_req(input logic [31:0] pc, input int drop_wait);
    logic [31:0] ea;
    ea = pc & 32'hFFFF_FFFC;
    pc_curr = pc; imem_ack = 1'b0; flush = 1'b0; stall = 1'b0;
    #1;
    drain();
    cyc();
    check_val("fr_req", {31'b0, imem_req}, 32'd1);
    cyc();
    flush = 1'b1;
    #1;
    check_val("fr_flush_pcw", {31'b0, pc_write}, 32'd0);
    cyc();
    flush = 1'b0;
    for (int i = 0; i < drop_wait; i++) begin
      #1;
      check_val("drop_req", {31'b0, imem_req}, 32'd1);
      check_val("drop_addr", imem_addr, ea);
      check_val("drop_valid", {31'b0, ifid_valid}, 32'd0);
      check_val("drop_pc4", ifid_pc4, 32'd0);
      check_val("drop_pcw", {31'b0, pc_write}, 32'd0);
      cyc();
    end
    imem_ack = 1'b1; imem_rdata = $urandom;
    #1;
    check_val("drop_ack_req", {31'b0, imem_req}, 32'd1);
    check_val("drop_ack_pcw", {31'b0, pc_write}, 32'd0);
    cyc();
    imem_ack = 1'b0;
    check_val("drop_done_req", {31'b0, imem_req}, 32'd0);
    check_val("drop_done_valid", {31'b0, ifid_valid}, 32'd0);
    $display("txn: flushed fetch at %h dropped", ea);
  endtask

  // Flush and ack in the same cycle.
  task automatic flush_ack(input logic [31:0] pc);
    pc_curr = pc; imem_ack = 1'b0; flush = 1'b0; stall = 1'b0;
    #1;
    drain();
    cyc();
    imem_ack = 1'b1; flush = 1'b1; imem_rdata = $urandom;
    #1;
    check_val("fa_pcw", {31'b0, pc_write}, 32'd0);
    cyc();
    imem_ack = 1'b0; flush = 1'b0;
    check_val("fa_req", {31'b0, imem_req}, 32'd0);
    check_val("fa_valid", {31'b0, ifid_valid}, 32'd0);
    check_val("fa_instr", ifid_instr, 32'd0);
    check_val("fa_pc4", ifid_pc4, 32'd0);
    $display("txn: flush+ack at %h discarded", pc);
  endtask

  // Reset during an outstanding request, then a stray ack, then a clean fetch.
  task automatic reset_mid(input logic [31:0] pc);
    logic [31:0] rd;
    pc_curr = pc; imem_ack = 1'b0; flush = 1'b0; stall = 1'b0;
    #1;
    drain();
    cyc();
    check_val("rm_req", {31'b0, imem_req}, 32'd1);
    reset = 1'b1;
    #1;
    check_val("rm_pcw_in_reset", {31'b0, pc_write}, 32'd0);
    cyc();
    reset = 1'b0;
    #1;
    check_val("rm_req0", {31'b0, imem_req}, 32'd0);
    check_val("rm_addr0", imem_addr, 32'd0);
    check_val("rm_valid0", {31'b0, ifid_valid}, 32'd0);
    check_val("rm_instr0", ifid_instr, 32'd0);
    check_val("rm_pc40", ifid_pc4, 32'd0);
    check_val("rm_pcw0", {31'b0, pc_write}, 32'd0);
    // Late ack while IDLE must not deliver anything.
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    check_val("stray_pcw", {31'b0, pc_write}, 32'd0);
    cyc();
    imem_ack = 1'b0;
    check_val("stray_valid", {31'b0, ifid_valid}, 32'd0);
    check_val("stray_req", {31'b0, imem_req}, 32'd1);
    check_val("stray_addr", imem_addr, pc & 32'hFFFF_FFFC);
    rd = $urandom;
    imem_ack = 1'b1; imem_rdata = rd;
    #1;
    check_val("post_rst_pcw", {31'b0, pc_write}, 32'd1);
    sb_q.push_back('{instr: rd, pc4: (pc & 32'hFFFF_FFFC) + 32'd4});
    cyc();
    imem_ack = 1'b0;
    $display("txn: reset mid-request at %h recovered", pc);
  endtask

  initial begin
    reset = 1'b1; pc_curr = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; flush = 1'b0;
    #1;
    check_val("rst_pcw", {31'b0, pc_write}, 32'd0);
    cyc(); cyc();
    check_val("rst_req", {31'b0, imem_req}, 32'd0);
    check_val("rst_addr", imem_addr, 32'd0);
    check_val("rst_valid", {31'b0, ifid_valid}, 32'd0);
    check_val("rst_instr", ifid_instr, 32'd0);
    check_val("rst_pc4", ifid_pc4, 32'd0);
    reset = 1'b0;

    fetch(32'h0040_0000, 1, -1);   // ack one cycle after req
    fetch(32'h0040_0004, 0, -1);   // zero-wait memory
    fetch(32'h0040_0008, 3, -1);   // ack delayed 3 cycles
    fetch(32'h0040_000C, 0, 2);    // stall at ack, held 2 more cycles
    flush_req(32'h0040_0010, 1);   // flush while request pending
    fetch(32'h0040_0100, 1, -1);   // next fetch uses new PC
    flush_ack(32'h0040_0104);      // flush and ack together
    fetch(32'hFFFF_FFFC, 0, -1);   // pc4 wraps to zero
    fetch(32'h0040_0002, 1, -1);   // unaligned PC is aligned down
    reset_mid(32'h0040_0200);
    for (int k = 0; k < 8; k++) begin
      fetch($urandom, $urandom_range(0, 2), int'($urandom_range(0, 3)) - 1);
    end

    // Final idle cycle drains the last delivery.
    pc_curr = 32'h0; flush = 1'b1; stall = 1'b0; imem_ack = 1'b0;
    #1;
    drain();
    check_val("sb_empty", sb_q.size(), 32'd0);
    cyc();
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
